// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/rca_w.sv
// WIDTH-bit ripple-carry adder chained from full_adder cells.
// Latency: combinational, one carry ripple across WIDTH cells.
// Backpressure: none.
module rca_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0]  = cin;
    assign carry_out = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier, one ripple add per cycle.
// Latency: done WIDTH+1 cycles after the accepting cycle; next accept WIDTH+2 cycles later.
// Backpressure: start is honoured only in IDLE; requests in RUN/DONE are dropped, not queued.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t         state;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH:0]   shifted;

    // acc_hi's top bit is always shifted out as zero; it only exists to hold the carry slot.
    wire unused_acc_top = acc_hi[WIDTH];

    assign addend  = acc_lo[0] ? mcand : '0;
    assign shifted = {carry, sum, acc_lo} >> 1;

    rca_w #(.WIDTH(WIDTH)) u_add (
        .a         (acc_hi[WIDTH-1:0]),
        .b         (addend),
        .cin       (1'b0),
        .sum       (sum),
        .carry_out (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            count     <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= multiplicand;
                        acc_lo <= multiplier;
                        acc_hi <= '0;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= shifted[2*WIDTH:WIDTH];
                    acc_lo <= shifted[WIDTH-1:0];
                    if (count == LAST) begin
                        product_q <= shifted[2*WIDTH-1:0];
                        state     <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=32: vector table plus multi-cycle corner sequences.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int errors;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        int             p1;
        int             p2;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present start in cycle 0, then observe cycles 1..40. p1/p2 re-pulse start mid-operation.
    task automatic run_vec(input vec_t v, input string name);
        int first_busy;
        int busy_n;
        int done_cyc;
        int done_n;
        logic [2*W-1:0] got;
        @(negedge clk);
        multiplicand = v.a;
        multiplier   = v.b;
        start        = 1'b1;
        first_busy = -1; busy_n = 0; done_cyc = -1; done_n = 0; got = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start        = (k == v.p1) || (k == v.p2);
            multiplicand = ~v.a;
            multiplier   = v.b ^ 32'h5A5A_5A5A;
            if (busy) begin
                if (first_busy < 0) first_busy = k;
                busy_n++;
            end
            if (done) begin
                if (done_cyc < 0) begin
                    done_cyc = k;
                    got      = product;
                end
                done_n++;
            end
            if (k == 34) check({name, " idle_c34"}, {62'd0, busy, done}, 64'd0);
        end
        check({name, " first_busy"}, 64'(first_busy), 64'd1);
        check({name, " busy_cycles"}, 64'(busy_n), 64'd32);
        check({name, " done_cycle"}, 64'(done_cyc), 64'd33);
        check({name, " done_pulses"}, 64'(done_n), 64'd1);
        check({name, " product"}, got, v.exp);
        check({name, " product_hold"}, product, v.exp);
    endtask

    vec_t vecs[8];

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{32'd7,          32'd6,          64'd42,                     0, 0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001,    0, 0};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'd0,                      0, 0};
        vecs[3] = '{32'h1234_5678,  32'd0,          64'd0,                      0, 0};
        vecs[4] = '{32'd3,          32'd5,          64'd15,                     5, 33};
        vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE,    0, 0};
        vecs[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000,    0, 0};
        vecs[7] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF,    0, 0};

        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset product", product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort in cycle 10 of a RUN: outputs clear at once, not a partial product.
        @(negedge clk);
        multiplicand = 32'd1000;
        multiplier   = 32'd1000;
        start        = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_abort busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{32'd2, 32'd9, 64'd18, 0, 0}, "post_abort");

        // start held high: one completion every W+2 cycles.
        begin
            int done_n;
            int exp_cyc;
            @(negedge clk);
            multiplicand = 32'h0001_0000;
            multiplier   = 32'h0001_0000;
            start        = 1'b1;
            done_n = 0;
            for (int k = 1; k < 200; k++) begin
                @(negedge clk);
                if (done) begin
                    exp_cyc = 33 + 34 * done_n;
                    check($sformatf("stream done%0d cycle", done_n), 64'(k), 64'(exp_cyc));
                    check($sformatf("stream done%0d product", done_n), product, 64'h0000_0001_0000_0000);
                    done_n++;
                end
            end
            start = 1'b0;
            check("stream done count", 64'(done_n), 64'd5);
        end

        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
